arith_seq: RTL and testbench
============================

# arith_seq

Parametrised multi-cycle arithmetic unit for the execute stage. It performs single-cycle add/subtract with full flags and iterative unsigned multiply (low/high) and divide/remainder behind a start/done handshake. It lets the core stall on long operations instead of instantiating a combinational multiplier/divider. It is the successor to the combinational add/sub unit, generalised in width and extended with multi-cycle operations, carry flag, flush and registered results.

## Interface
Parameters:
- WIDTH, 32, operand/result width; legal range ≥ 2.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted on a rising edge where start && ready.
- op  in  3  000 ADD, 001 SUB, 010 MUL, 011 MULHU, 100 DIVU, 101 REMU; 110/111 reserved.
- a  in  WIDTH  operand A; sampled on accept.
- b  in  WIDTH  operand B; sampled on accept.
- flush  in  1  synchronous cancel of an in-flight operation.
- ready  out  1  unit can accept an operation this cycle.
- done  out  1  one-cycle pulse: result and flags are valid.
- result  out  WIDTH  registered result; held until the next completion.
- z, n, v, c  out  1 each  zero, negative (result MSB), signed overflow, carry.

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE → DONE on accepting ADD/SUB, or on a divide with b==0.
  - IDLE → CALC on accepting MUL/MULHU/DIVU/REMU.
  - CALC → DONE when the iteration counter reaches WIDTH.
  - DONE → IDLE if nothing is accepted. DONE → DONE or CALC on a back-to-back accept, using the same rules as from IDLE.
- ready = 1 in IDLE and DONE, 0 in CALC. done = 1 only in DONE.
- ADD: result = a + b. SUB: result = a + ~b + 1.
  - c = carry out of the WIDTH-bit adder. For SUB, c=1 means no borrow.
  - v = (a_msb == b'_msb) && (result_msb != a_msb), where b' = b for ADD and ~b for SUB.
- MUL/MULHU: shift-add, one partial-product bit per cycle, over a 2·WIDTH accumulator.
  - MUL returns the low WIDTH bits; MULHU returns the high WIDTH bits.
  - Operands are unsigned.
- DIVU/REMU: restoring division, one quotient bit per cycle.
  - DIVU returns the quotient; REMU returns the remainder.
  - Divide by zero bypasses CALC: DIVU returns all ones, REMU returns a.
- Flags for MUL/DIV ops: z and n are computed from result; v = c = 0.
- Reserved op: treated as ADD.
- The iteration counter is $clog2(WIDTH+1) bits wide and is cleared on accept.
- flush:
  - In CALC: go to IDLE next edge, no done pulse, result/flags unchanged.
  - In IDLE/DONE: no effect on the FSM. A simultaneous start is ignored (flush wins).
- Operands a/b/op may change freely after accept; internal copies are used.

## Timing
- Reset (n_rst=0, asynchronous): state=IDLE, ready=1, done=0, result=0, z=n=v=c=0, counter=0, internal registers 0.
- Deasserting reset mid-operation leaves the unit idle; the lost operation produces no done.
- ADD/SUB, divide-by-zero: accepted at edge k → result/flags updated and done=1 in the cycle after edge k (latency 1).
- MUL/MULHU/DIVU/REMU: accepted at edge k → iterations at edges k+1..k+WIDTH → done=1 in the cycle after edge k+WIDTH (latency WIDTH+1).
- done is high for exactly one cycle per completed operation. result/flags stay stable until the next completion or reset.
- Back-to-back: start in a DONE cycle is accepted at that same edge. Throughput is 1/cycle for ADD/SUB and 1/(WIDTH+1) for iterative ops.
- Flags update only together with result, at the done-producing edge.

## Test plan
- Reset then ADD a=0x7FFFFFFF, b=0x00000001 (WIDTH=32) → done 1 cycle after accept; result=0x80000000, n=1, v=1, c=0, z=0.
- SUB a=b=0x12345678 → result=0, z=1, c=1, v=0. Then SUB 0 − 1 → 0xFFFFFFFF, n=1, c=0.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → ready=0 for 32 cycles, done 33 cycles after accept, result=0xFFFFFFFE. MUL with the same operands → 0x00000001.
- DIVU 100/7 → 14. REMU 100/7 → 2, latency 33. DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, both latency 1.
- MUL 3×4 with flush asserted on cycle 10 of CALC → no done, ready=1 next cycle, result keeps its previous value. A following ADD 2+3 → 5.
- Back-to-back ADD 1+1 then ADD 2+2 with start held → done on two consecutive cycles with results 2 then 4. Repeat at WIDTH=8: MUL 0xFF×0xFF → 0x01, MULHU → 0xFE, latency 9.

Source files
------------

// File: rtl/arith_seq.sv
// -----------------------------------------------------------------------------
// arith_seq
//
// Multi-cycle arithmetic unit for the execute stage. ADD/SUB finish in one
// cycle with full Z/N/V/C flags. MUL/MULHU (unsigned shift-add) and DIVU/REMU
// (unsigned restoring division) iterate one bit per cycle behind a start/done
// handshake, so the core can stall on them instead of carrying a wide
// combinational multiplier or divider.
//
// Ports
//   clk     in   1      rising-edge clock
//   n_rst   in   1      asynchronous active-low reset
//   start   in   1      request, accepted on an edge where start && ready
//   op      in   3      000 ADD, 001 SUB, 010 MUL, 011 MULHU, 100 DIVU,
//                       101 REMU, 110/111 reserved (executed as ADD)
//   a, b    in   WIDTH  operands, captured on accept
//   flush   in   1      cancels an in-flight iterative op; blocks accepts
//   ready   out  1      an operation can be accepted this cycle
//   done    out  1      one-cycle pulse, result and flags valid
//   result  out  WIDTH  registered result, held until the next completion
//   z,n,v,c out  1      zero, negative, signed overflow, carry
// -----------------------------------------------------------------------------
module arith_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             n,
  output logic             v,
  output logic             c
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_MUL   = 3'b010;
  localparam logic [2:0] OP_MULHU = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_REMU  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             v;
    logic             c;
  } addsub_t;

  // ---------------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------------

  // Single WIDTH-bit adder shared by ADD and SUB: SUB feeds ~b with carry-in 1,
  // so c is the true adder carry (1 means "no borrow" for SUB).
  function automatic addsub_t add_sub(input logic [WIDTH-1:0] x,
                                      input logic [WIDTH-1:0] y,
                                      input logic             sub);
    addsub_t          r;
    logic [WIDTH-1:0] y_eff;
    logic [WIDTH:0]   sum;
    y_eff = sub ? ~y : y;
    sum   = {1'b0, x} + {1'b0, y_eff} + (WIDTH+1)'(sub);
    r.res = sum[WIDTH-1:0];
    r.c   = sum[WIDTH];
    r.v   = (x[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
    return r;
  endfunction

  // One shift-add step. {hi,lo} is the 2*WIDTH accumulator; the multiplier
  // starts in lo and is consumed from the LSB while product bits shift in
  // from the top. After WIDTH steps {hi,lo} holds the full product.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [WIDTH-1:0] hi,
                                                  input logic [WIDTH-1:0] lo,
                                                  input logic [WIDTH-1:0] mcand);
    logic [WIDTH:0] sum;
    sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    return {sum, lo[WIDTH-1:1]};
  endfunction

  // One restoring-division step. hi is the partial remainder, lo shifts the
  // dividend out of its MSB and the quotient bits into its LSB. After WIDTH
  // steps lo holds the quotient and hi the remainder. The partial remainder
  // is always below the divisor, so after the trial subtract it fits WIDTH.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] hi,
                                                  input logic [WIDTH-1:0] lo,
                                                  input logic [WIDTH-1:0] dvsr);
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] rem;
    shifted = {hi, lo[WIDTH-1]};
    ge      = (shifted >= {1'b0, dvsr});
    rem     = ge ? WIDTH'(shifted - {1'b0, dvsr}) : WIDTH'(shifted);
    return {rem, lo[WIDTH-2:0], ge};
  endfunction

  // ---------------------------------------------------------------------------
  // State and internal operand copies
  // ---------------------------------------------------------------------------
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opnd_q;   // multiplicand or divisor
  logic             is_div_q; // iterate with div_step instead of mul_step
  logic             sel_hi_q; // MULHU/REMU take the upper accumulator half

  // ---------------------------------------------------------------------------
  // Combinational next-value logic
  // ---------------------------------------------------------------------------
  logic             accept;
  addsub_t          as_res;
  logic [WIDTH-1:0] dz_res;
  logic [2*WIDTH-1:0] step;
  logic [WIDTH-1:0] fin_res;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    // flush always beats start, whatever state we are in
    accept  = start && ready && !flush;
    as_res  = add_sub(a, b, op == OP_SUB);
    dz_res  = (op == OP_DIVU) ? {WIDTH{1'b1}} : a;
    step    = is_div_q ? div_step(hi_q, lo_q, opnd_q)
                       : mul_step(hi_q, lo_q, opnd_q);
    fin_res = sel_hi_q ? step[2*WIDTH-1:WIDTH] : step[WIDTH-1:0];
    cnt_nxt = cnt + CNT_W'(1);
  end

  // ---------------------------------------------------------------------------
  // FSM, datapath registers and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      sel_hi_q <= 1'b0;
      ready    <= 1'b1;
      done     <= 1'b0;
      result   <= '0;
      z        <= 1'b0;
      n        <= 1'b0;
      v        <= 1'b0;
      c        <= 1'b0;
    end else begin
      case (state)
        CALC: begin
          if (flush) begin
            // abandon the operation; result and flags keep the last completion
            state <= IDLE;
            ready <= 1'b1;
            done  <= 1'b0;
          end else begin
            hi_q <= step[2*WIDTH-1:WIDTH];
            lo_q <= step[WIDTH-1:0];
            cnt  <= cnt_nxt;
            if (cnt_nxt == CNT_LAST) begin
              state  <= DONE;
              ready  <= 1'b1;
              done   <= 1'b1;
              result <= fin_res;
              z      <= (fin_res == '0);
              n      <= fin_res[WIDTH-1];
              v      <= 1'b0;
              c      <= 1'b0;
            end
          end
        end

        default: begin
          // IDLE and DONE behave alike: accept a new op or fall back to IDLE
          state <= IDLE;
          ready <= 1'b1;
          done  <= 1'b0;
          if (accept) begin
            cnt <= '0;
            case (op)
              OP_MUL, OP_MULHU: begin
                hi_q     <= '0;
                lo_q     <= a;
                opnd_q   <= b;
                is_div_q <= 1'b0;
                sel_hi_q <= (op == OP_MULHU);
                state    <= CALC;
                ready    <= 1'b0;
              end
              OP_DIVU, OP_REMU: begin
                if (b == '0) begin
                  // divide by zero resolves immediately without iterating
                  state  <= DONE;
                  done   <= 1'b1;
                  result <= dz_res;
                  z      <= (dz_res == '0);
                  n      <= dz_res[WIDTH-1];
                  v      <= 1'b0;
                  c      <= 1'b0;
                end else begin
                  hi_q     <= '0;
                  lo_q     <= a;
                  opnd_q   <= b;
                  is_div_q <= 1'b1;
                  sel_hi_q <= (op == OP_REMU);
                  state    <= CALC;
                  ready    <= 1'b0;
                end
              end
              default: begin
                // ADD, SUB and the reserved encodings
                state  <= DONE;
                done   <= 1'b1;
                result <= as_res.res;
                z      <= (as_res.res == '0);
                n      <= as_res.res[WIDTH-1];
                v      <= as_res.v;
                c      <= as_res.c;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arith_seq.sv
// -----------------------------------------------------------------------------
// tb_arith_seq
//
// Testbench for arith_seq. Two instances are exercised: WIDTH=32 and WIDTH=8.
// Each issued operation pushes its expected result/flags/latency, computed by
// a small reference model, into a scoreboard queue; the entry is popped and
// compared when the DUT raises done.
// -----------------------------------------------------------------------------
module tb_arith_seq;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_MUL   = 3'b010;
  localparam logic [2:0] OP_MULHU = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_REMU  = 3'b101;

  logic clk;
  logic n_rst;

  logic        start32, flush32, ready32, done32, z32, n32, v32, c32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, result32;

  logic        start8, flush8, ready8, done8, z8, n8, v8, c8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, result8;

  arith_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .n_rst(n_rst), .start(start32), .op(op32), .a(a32), .b(b32),
    .flush(flush32), .ready(ready32), .done(done32), .result(result32),
    .z(z32), .n(n32), .v(v32), .c(c32)
  );

  arith_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .n_rst(n_rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .flush(flush8), .ready(ready8), .done(done8), .result(result8),
    .z(z8), .n(n8), .v(v8), .c(c8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        z, n, v, c;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model, independent of the RTL structure.
  function automatic exp_t model(input int w, input logic [2:0] o,
                                 input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [63:0] mask;
    logic [63:0] p;
    logic [64:0] s;
    logic [31:0] yy;
    logic        sub;
    mask  = (64'd1 << w) - 64'd1;
    p     = {32'b0, x} * {32'b0, y};
    e.v   = 1'b0;
    e.c   = 1'b0;
    e.lat = w + 1;
    case (o)
      OP_MUL:   e.res = 32'(p & mask);
      OP_MULHU: e.res = 32'((p >> w) & mask);
      OP_DIVU: begin
        if (y == 0) begin e.res = mask[31:0]; e.lat = 1; end
        else e.res = x / y;
      end
      OP_REMU: begin
        if (y == 0) begin e.res = x; e.lat = 1; end
        else e.res = x % y;
      end
      default: begin
        sub   = (o == OP_SUB);
        yy    = sub ? (~y & mask[31:0]) : y;
        s     = {33'b0, x} + {33'b0, yy} + {64'b0, sub};
        e.res = 32'(s & {1'b0, mask});
        e.c   = s[w];
        e.v   = (x[w-1] == yy[w-1]) && (e.res[w-1] != x[w-1]);
        e.lat = 1;
      end
    endcase
    e.z = (e.res == 32'd0);
    e.n = e.res[w-1];
    return e;
  endfunction

  function automatic exp_t observe(input bit w8);
    exp_t o;
    o.res = w8 ? {24'b0, result8} : result32;
    o.z   = w8 ? z8 : z32;
    o.n   = w8 ? n8 : n32;
    o.v   = w8 ? v8 : v32;
    o.c   = w8 ? c8 : c32;
    o.lat = 0;
    return o;
  endfunction

  // Drive one request (call just after a falling edge) and record expectation.
  task automatic drive(input bit w8, input logic [2:0] o,
                       input logic [31:0] x, input logic [31:0] y);
    logic [31:0] xm, ym;
    xm = w8 ? {24'b0, x[7:0]} : x;
    ym = w8 ? {24'b0, y[7:0]} : y;
    if (w8) begin
      start8 = 1'b1; op8 = o; a8 = xm[7:0]; b8 = ym[7:0];
    end else begin
      start32 = 1'b1; op32 = o; a32 = xm; b32 = ym;
    end
    sb.push_back(model(w8 ? 8 : 32, o, xm, ym));
  endtask

  // Wait (bounded) for done; drops start and scrambles operands after accept.
  task automatic wait_done(input bit w8, output int lat, output int busy);
    bit fin;
    lat  = 0;
    busy = 0;
    fin  = 0;
    while (!fin) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        if (w8) begin
          start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); op8 = 3'($urandom);
        end else begin
          start32 = 1'b0; a32 = $urandom; b32 = $urandom; op32 = 3'($urandom);
        end
      end
      if (!(w8 ? ready8 : ready32)) busy++;
      if (w8 ? done8 : done32) fin = 1;
      else if (lat > 100) begin lat = -1; fin = 1; end
    end
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ready32, done32, result32, z32, n32, v32, c32} !== {1'b1, 1'b0, 32'd0, 4'b0}) begin
      n_fail++;
      $display("FAIL reset32: got ready=%b done=%b res=%h flags=%b%b%b%b required 1 0 0 0000",
               ready32, done32, result32, z32, n32, v32, c32);
    end
    n_checks++;
    if ({ready8, done8, result8, z8, n8, v8, c8} !== {1'b1, 1'b0, 8'd0, 4'b0}) begin
      n_fail++;
      $display("FAIL reset8: got ready=%b done=%b res=%h required 1 0 0", ready8, done8, result8);
    end
    n_rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ready32, done32} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release: got ready=%b done=%b required 1 0", ready32, done32);
    end
  endtask

  task automatic test_addsub;
    logic [2:0]  ops [6] = '{OP_ADD, OP_SUB, OP_SUB, OP_ADD, 3'b110, 3'b111};
    logic [31:0] as  [6] = '{32'h7FFFFFFF, 32'h12345678, 32'h0, 32'hFFFFFFFF, 32'd5, 32'h80000000};
    logic [31:0] bs  [6] = '{32'h1, 32'h12345678, 32'h1, 32'h1, 32'd6, 32'h80000000};
    exp_t e, o;
    int   lat, busy;
    for (int i = 0; i < 6; i++) begin
      drive(0, ops[i], as[i], bs[i]);
      wait_done(0, lat, busy);
      e = sb.pop_front();
      o = observe(0);
      n_checks++;
      if (lat !== e.lat) begin
        n_fail++;
        $display("FAIL addsub%0d_latency: got %0d required %0d", i, lat, e.lat);
      end
      n_checks++;
      if ({o.res, o.z, o.n, o.v, o.c} !== {e.res, e.z, e.n, e.v, e.c}) begin
        n_fail++;
        $display("FAIL addsub%0d_result: got %h znvc=%b%b%b%b required %h znvc=%b%b%b%b",
                 i, o.res, o.z, o.n, o.v, o.c, e.res, e.z, e.n, e.v, e.c);
      end
      if (i == 0) begin
        n_checks++;
        if ({o.res, o.z, o.n, o.v, o.c} !== {32'h80000000, 4'b0110}) begin
          n_fail++;
          $display("FAIL add_ovf_const: got %h znvc=%b%b%b%b required 80000000 znvc=0110",
                   o.res, o.z, o.n, o.v, o.c);
        end
      end
    end
  endtask

  task automatic test_mul;
    logic [2:0] ops [2] = '{OP_MULHU, OP_MUL};
    logic [31:0] want [2] = '{32'hFFFFFFFE, 32'h00000001};
    exp_t e, o;
    int   lat, busy;
    for (int i = 0; i < 2; i++) begin
      drive(0, ops[i], 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(0, lat, busy);
      e = sb.pop_front();
      o = observe(0);
      n_checks++;
      if (lat !== e.lat || busy !== 32) begin
        n_fail++;
        $display("FAIL mul%0d_timing: got latency %0d busy %0d required %0d and 32", i, lat, busy, e.lat);
      end
      n_checks++;
      if ({o.res, o.z, o.n, o.v, o.c} !== {e.res, e.z, e.n, e.v, e.c} || o.res !== want[i]) begin
        n_fail++;
        $display("FAIL mul%0d_result: got %h znvc=%b%b%b%b required %h znvc=%b%b%b%b",
                 i, o.res, o.z, o.n, o.v, o.c, e.res, e.z, e.n, e.v, e.c);
      end
      @(negedge clk);
      n_checks++;
      if (done32 !== 1'b0) begin
        n_fail++;
        $display("FAIL mul%0d_pulse: done still %b one cycle later, required 0", i, done32);
      end
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops [4] = '{OP_DIVU, OP_REMU, OP_REMU, OP_DIVU};
    logic [31:0] bs  [4] = '{32'd7, 32'd7, 32'd0, 32'd0};
    logic [31:0] as  [4] = '{32'd100, 32'd100, 32'd5, 32'd5};
    logic [31:0] want[4] = '{32'd14, 32'd2, 32'd5, 32'hFFFFFFFF};
    exp_t e, o;
    int   lat, busy;
    for (int i = 0; i < 4; i++) begin
      drive(0, ops[i], as[i], bs[i]);
      wait_done(0, lat, busy);
      e = sb.pop_front();
      o = observe(0);
      n_checks++;
      if (lat !== e.lat) begin
        n_fail++;
        $display("FAIL div%0d_latency: got %0d required %0d", i, lat, e.lat);
      end
      n_checks++;
      if ({o.res, o.z, o.n, o.v, o.c} !== {e.res, e.z, e.n, e.v, e.c} || o.res !== want[i]) begin
        n_fail++;
        $display("FAIL div%0d_result: got %h znvc=%b%b%b%b required %h znvc=%b%b%b%b",
                 i, o.res, o.z, o.n, o.v, o.c, e.res, e.z, e.n, e.v, e.c);
      end
    end
  endtask

  task automatic test_flush;
    exp_t prev, o, e;
    int   seen, lat, busy;
    prev = observe(0);
    @(negedge clk);
    start32 = 1'b1; op32 = OP_MUL; a32 = 32'd3; b32 = 32'd4;
    @(negedge clk);
    start32 = 1'b0;
    repeat (9) @(negedge clk);
    flush32 = 1'b1;                 // tenth CALC cycle
    @(negedge clk);
    flush32 = 1'b0;
    n_checks++;
    if ({ready32, done32} !== 2'b10) begin
      n_fail++;
      $display("FAIL flush_calc: got ready=%b done=%b required 1 0", ready32, done32);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done32) seen++;
    end
    o = observe(0);
    n_checks++;
    if (seen !== 0 || {o.res, o.z, o.n, o.v, o.c} !== {prev.res, prev.z, prev.n, prev.v, prev.c}) begin
      n_fail++;
      $display("FAIL flush_hold: got %0d dones, res %h required 0 dones, res %h", seen, o.res, prev.res);
    end
    // flush in idle beats a simultaneous start
    start32 = 1'b1; flush32 = 1'b1; op32 = OP_ADD; a32 = 32'd9; b32 = 32'd9;
    @(negedge clk);
    start32 = 1'b0; flush32 = 1'b0;
    n_checks++;
    if (done32 !== 1'b0 || result32 !== prev.res) begin
      n_fail++;
      $display("FAIL flush_idle: got done=%b res=%h required 0 and %h", done32, result32, prev.res);
    end
    drive(0, OP_ADD, 32'd2, 32'd3);
    wait_done(0, lat, busy);
    e = sb.pop_front();
    o = observe(0);
    n_checks++;
    if (lat !== e.lat || o.res !== 32'd5 || o.res !== e.res) begin
      n_fail++;
      $display("FAIL flush_then_add: got %h latency %0d required 5 latency %0d", o.res, lat, e.lat);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    @(negedge clk);
    drive(0, OP_ADD, 32'd1, 32'd1);
    @(negedge clk);
    drive(0, OP_ADD, 32'd2, 32'd2);  // start held through the DONE cycle
    e = sb.pop_front();
    n_checks++;
    if (done32 !== 1'b1 || result32 !== e.res || result32 !== 32'd2) begin
      n_fail++;
      $display("FAIL b2b_first: got done=%b res=%h required 1 and 2", done32, result32);
    end
    @(negedge clk);
    start32 = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (done32 !== 1'b1 || result32 !== e.res || result32 !== 32'd4) begin
      n_fail++;
      $display("FAIL b2b_second: got done=%b res=%h required 1 and 4", done32, result32);
    end
    @(negedge clk);
    n_checks++;
    if (done32 !== 1'b0 || result32 !== 32'd4) begin
      n_fail++;
      $display("FAIL b2b_end: got done=%b res=%h required 0 and 4", done32, result32);
    end
  endtask

  task automatic test_random;
    exp_t        e, o;
    int          lat, busy;
    logic [31:0] x, y;
    for (int i = 0; i < 10; i++) begin
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      drive(0, 3'($urandom_range(0, 7)), x, y);
      wait_done(0, lat, busy);
      e = sb.pop_front();
      o = observe(0);
      n_checks++;
      if (lat !== e.lat || {o.res, o.z, o.n, o.v, o.c} !== {e.res, e.z, e.n, e.v, e.c}) begin
        n_fail++;
        $display("FAIL random%0d: got %h znvc=%b%b%b%b lat %0d required %h znvc=%b%b%b%b lat %0d",
                 i, o.res, o.z, o.n, o.v, o.c, lat, e.res, e.z, e.n, e.v, e.c, e.lat);
      end
    end
  endtask

  task automatic test_reset_midop;
    int seen;
    @(negedge clk);
    start32 = 1'b1; op32 = OP_DIVU; a32 = 32'd1000; b32 = 32'd3;
    @(negedge clk);
    start32 = 1'b0;
    repeat (4) @(negedge clk);
    n_rst = 1'b0;
    #2;
    n_rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ready32, done32, result32} !== {1'b1, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_midop: got ready=%b done=%b res=%h required 1 0 0", ready32, done32, result32);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done32) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_lost_op: got %0d done pulses required 0", seen);
    end
  endtask

  task automatic test_w8;
    logic [2:0]  ops [3] = '{OP_MUL, OP_MULHU, OP_ADD};
    logic [31:0] as  [3] = '{32'hFF, 32'hFF, 32'h7F};
    logic [31:0] bs  [3] = '{32'hFF, 32'hFF, 32'h01};
    logic [31:0] want[3] = '{32'h01, 32'hFE, 32'h80};
    exp_t e, o;
    int   lat, busy;
    for (int i = 0; i < 3; i++) begin
      drive(1, ops[i], as[i], bs[i]);
      wait_done(1, lat, busy);
      e = sb.pop_front();
      o = observe(1);
      n_checks++;
      if (lat !== e.lat || (i < 2 && lat !== 9)) begin
        n_fail++;
        $display("FAIL w8_%0d_latency: got %0d required %0d", i, lat, e.lat);
      end
      n_checks++;
      if ({o.res, o.z, o.n, o.v, o.c} !== {e.res, e.z, e.n, e.v, e.c} || o.res !== want[i]) begin
        n_fail++;
        $display("FAIL w8_%0d_result: got %h znvc=%b%b%b%b required %h znvc=%b%b%b%b",
                 i, o.res, o.z, o.n, o.v, o.c, e.res, e.z, e.n, e.v, e.c);
      end
    end
  endtask

  initial begin
    n_rst   = 1'b0;
    start32 = 1'b0; flush32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    start8  = 1'b0; flush8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
    test_reset();
    test_addsub();
    test_mul();
    test_div();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_midop();
    test_w8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
